ps2_key_event_decoder: RTL and testbench
========================================

// Module: ps2_key_event_decoder
// PURPOSE
//  Sits between ps2_kbd (byte FIFO on cpu_clk) and the CPU keyboard MMIO port.
//  Pops PS/2 set-2 scancode bytes and folds E0/F0 prefixes into single key events.
//  Buffers the events in a small show-ahead FIFO that the CPU drains one word at a time.
//  Non-key bytes are filtered out (BAT 0xAA, ACK 0xFA, resend 0xFE, errors 0x00/0xFF).
// PARAMETERS
//  DEPTH_LOG2  3  event FIFO depth = 2**DEPTH_LOG2 entries (default 8)
// PORTS
//  clk             in   1               cpu_clk; all state changes on its rising edge
//  rst             in   1               asynchronous, active-high reset
//  kbd_ready       in   1               ps2_kbd holds an unread byte on kbd_data
//  kbd_data        in   8               ps2_kbd head byte; valid while kbd_ready=1
//  kbd_overflow    in   1               ps2_kbd dropped a byte
//  kbd_read_enable out  1               one-cycle pop strobe to ps2_kbd
//  evt_valid       out  1               event FIFO not empty
//  evt_data        out  10              head event {ext[9], rel[8], code[7:0]}
//  evt_pop         in   1               CPU consumes the head event
//  evt_count       out  DEPTH_LOG2+1    current occupancy, 0..2**DEPTH_LOG2
//  sync_lost       out  1               sticky: kbd_overflow was seen
//  clr_sync_lost   in   1               clears sync_lost
// BEHAVIOUR
//  Reset (async): FSM=IDLE, FIFO empty, cooldown=0, sync_lost=0.
//   All outputs read 0; kbd_read_enable is forced 0 while rst=1.
//  Fetch rule (combinational): kbd_read_enable = kbd_ready & ~fifo_full & ~cooldown & ~rst.
//   kbd_data is sampled on the same edge as the strobe.
//   cooldown is set for one cycle after every strobe, so at most one byte is read per 2 cycles.
//   Backpressure: no byte is read while the FIFO is full; bytes wait in ps2_kbd.
//  FSM states: IDLE, EXT (E0 seen), REL (F0 seen), EXT_REL (E0 F0 seen).
//   E0: IDLE->EXT. In any other state, FSM goes to EXT (restart the sequence).
//   F0: IDLE->REL, EXT->EXT_REL. In REL/EXT_REL, the byte is ignored and the state is held.
//   Filtered byte (AA/FA/FE/00/FF): dropped, FSM->IDLE, no event is produced.
//   Any other byte: push {ext, rel, byte}, then FSM->IDLE.
//    ext = state is EXT or EXT_REL; rel = state is REL or EXT_REL.
//   E1 (pause key) is not special-cased and is emitted as an ordinary code.
//  Latency: a byte strobed at edge N appears on evt_valid/evt_data right after edge N.
//  FIFO: show-ahead. evt_data = head entry when evt_valid=1, else 10'h000.
//   evt_pop with evt_valid=0 is ignored.
//   Push and pop on the same edge: count unchanged, head advances.
//   Pointers wrap modulo 2**DEPTH_LOG2; count distinguishes full from empty.
//  kbd_overflow=1 on any edge: sync_lost<=1 and FSM->IDLE, discarding any partial prefix.
//   Events already in the FIFO are kept.
//   If a byte is strobed on that same edge, it is decoded from IDLE.
//  clr_sync_lost and kbd_overflow on the same edge: set wins.
//  Reset mid-sequence (for example after E0): prefix and FIFO are lost and FSM=IDLE.
// TESTING
//  1 Assert rst mid-run -> evt_valid=0, evt_count=0, sync_lost=0, kbd_read_enable=0 immediately.
//  2 Bytes 1C; F0 1C -> events 10'h01C then 10'h11C; strobes are at least 2 cycles apart.
//  3 Bytes E0 75; E0 F0 75 -> events 10'h275 then 10'h375; F0 F0 1C -> 10'h11C.
//  4 Nine make codes, no pops -> count=8, kbd_read_enable stays 0 with kbd_ready=1.
//    One pop -> ninth byte read, count returns to 8.
//    Pop and push on the same edge -> count stays constant.
//  5 Bytes E0 AA 1C -> AA dropped, event 10'h01C; bytes FA 00 FF -> no events.
//  6 kbd_overflow pulse after F0 -> sync_lost=1; next 1C -> 10'h01C.
//    clr_sync_lost -> sync_lost=0; clr together with overflow -> sync_lost stays 1.

Source files
------------

// File: rtl/ps2_key_event_decoder_if.sv
// Signal bundle between the PS/2 byte FIFO, the key event decoder and the CPU
// keyboard port. The decoder uses the slave view; its environment uses master.
interface ps2_key_event_decoder_if #(
  parameter int DEPTH_LOG2 = 3
);
  logic                  kbd_ready;
  logic [7:0]            kbd_data;
  logic                  kbd_overflow;
  logic                  kbd_read_enable;
  logic                  evt_valid;
  logic [9:0]            evt_data;
  logic                  evt_pop;
  logic [DEPTH_LOG2:0]   evt_count;
  logic                  sync_lost;
  logic                  clr_sync_lost;

  modport master (
    output kbd_ready, kbd_data, kbd_overflow, evt_pop, clr_sync_lost,
    input  kbd_read_enable, evt_valid, evt_data, evt_count, sync_lost
  );

  modport slave (
    input  kbd_ready, kbd_data, kbd_overflow, evt_pop, clr_sync_lost,
    output kbd_read_enable, evt_valid, evt_data, evt_count, sync_lost
  );
endinterface

// File: rtl/ps2_key_event_decoder.sv
// Folds PS/2 set-2 E0/F0 prefixes into {ext, rel, code} key events and
// buffers them in a show-ahead FIFO drained by the CPU.
module ps2_key_event_decoder #(
  parameter int DEPTH_LOG2 = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  ps2_key_event_decoder_if.slave   bus
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_COUNT = (DEPTH_LOG2 + 1)'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXT,
    ST_REL,
    ST_EXT_REL
  } state_t;

  state_t                state;
  state_t                state_d;
  state_t                cur;
  logic                  cooldown;
  logic                  rd_en;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  push;
  logic                  pop_ok;
  logic                  ext;
  logic                  rel;
  logic [9:0]            push_data;
  logic [9:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [DEPTH_LOG2:0]   count;
  logic                  sync_lost;

  assign fifo_full  = (count == FULL_COUNT);
  assign fifo_empty = (count == '0);

  // At most one byte every second cycle, and never into a full FIFO.
  assign rd_en  = bus.kbd_ready & ~fifo_full & ~cooldown & ~rst;
  assign pop_ok = bus.evt_pop & ~fifo_empty;

  assign bus.kbd_read_enable = rd_en;
  assign bus.evt_valid       = ~fifo_empty;
  assign bus.evt_data        = fifo_empty ? 10'h000 : mem[rd_ptr];
  assign bus.evt_count       = count;
  assign bus.sync_lost       = sync_lost;

  // NOTE: every variable gets a default at the top of always_comb so no path
  // leaves it unassigned; a missing default infers a latch.
  always_comb begin
    // An overflow on this edge discards any partial prefix before decoding.
    cur       = bus.kbd_overflow ? ST_IDLE : state;
    state_d   = cur;
    push      = 1'b0;
    ext       = (cur == ST_EXT) || (cur == ST_EXT_REL);
    rel       = (cur == ST_REL) || (cur == ST_EXT_REL);
    push_data = {ext, rel, bus.kbd_data};
    if (rd_en) begin
      if (bus.kbd_data == 8'hE0) begin
        state_d = ST_EXT;
      end else if (bus.kbd_data == 8'hF0) begin
        case (cur)
          ST_IDLE: state_d = ST_REL;
          ST_EXT:  state_d = ST_EXT_REL;
          default: state_d = cur;
        endcase
      end else if (bus.kbd_data inside {8'hAA, 8'hFA, 8'hFE, 8'h00, 8'hFF}) begin
        state_d = ST_IDLE;
      end else begin
        push    = 1'b1;
        state_d = ST_IDLE;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      cooldown  <= 1'b0;
      sync_lost <= 1'b0;
    end else begin
      state    <= state_d;
      cooldown <= rd_en;
      if (bus.kbd_overflow) begin
        sync_lost <= 1'b1;
      end else if (bus.clr_sync_lost) begin
        sync_lost <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: the storage array is not reset; count gates every read, so stale
  // entries are never visible and the array can map onto plain RAM.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= push_data;
    end
  end

endmodule

// File: tb/tb_ps2_key_event_decoder.sv
// Directed bench: a byte queue stands in for ps2_kbd, events are popped and
// compared against hand-computed values.
module tb_ps2_key_event_decoder;

  logic clk;
  logic rst;

  ps2_key_event_decoder_if #(.DEPTH_LOG2(3)) bus ();

  ps2_key_event_decoder #(.DEPTH_LOG2(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cycle = 0;
  int last_stb = -1;
  int min_gap = 1000;
  logic [7:0] byte_q[$];

  task automatic upd_kbd();
    bus.kbd_ready = (byte_q.size() != 0);
    bus.kbd_data  = (byte_q.size() != 0) ? byte_q[0] : 8'h00;
  endtask

  task automatic feed(input logic [7:0] b);
    byte_q.push_back(b);
    upd_kbd();
  endtask

  // Called at a falling edge; crosses one rising edge and returns at the next
  // falling edge with one-cycle pulses cleared.
  task automatic cyc();
    logic stb;
    #1;
    stb = bus.kbd_read_enable;
    if (stb) begin
      if (last_stb >= 0 && (cycle - last_stb) < min_gap) min_gap = cycle - last_stb;
      last_stb = cycle;
    end
    @(negedge clk);
    cycle++;
    if (stb) void'(byte_q.pop_front());
    bus.evt_pop       = 1'b0;
    bus.kbd_overflow  = 1'b0;
    bus.clr_sync_lost = 1'b0;
    upd_kbd();
  endtask

  task automatic drain(input int budget, output bit timed_out);
    int n = 0;
    while (byte_q.size() != 0 && n < budget) begin
      cyc();
      n++;
    end
    timed_out = (byte_q.size() != 0);
  endtask

  task automatic pop_head();
    bus.evt_pop = 1'b1;
    cyc();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (bus.evt_valid !== 1'b0 || bus.evt_count !== 4'd0 || bus.sync_lost !== 1'b0 ||
        bus.kbd_read_enable !== 1'b0 || bus.evt_data !== 10'h000) begin
      errors++;
      $display("FAIL reset_state: valid=%b count=%0d sync=%b rd=%b data=%h, want all 0",
               bus.evt_valid, bus.evt_count, bus.sync_lost, bus.kbd_read_enable, bus.evt_data);
    end
    rst = 1'b0;
    cyc();
  endtask

  task automatic test_basic();
    bit to;
    logic [9:0] exp [2] = '{10'h01C, 10'h11C};
    min_gap = 1000;
    last_stb = -1;
    feed(8'h1C); feed(8'hF0); feed(8'h1C);
    drain(30, to);
    checks++;
    if (to) begin errors++; $display("FAIL basic_drain: bytes left=%0d, want 0", byte_q.size()); end
    checks++;
    if (bus.evt_count !== 4'd2) begin
      errors++; $display("FAIL basic_count: got %0d, want 2", bus.evt_count);
    end
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (bus.evt_valid !== 1'b1 || bus.evt_data !== exp[i]) begin
        errors++;
        $display("FAIL basic_event%0d: valid=%b data=%h, want %h", i, bus.evt_valid, bus.evt_data, exp[i]);
      end
      pop_head();
    end
    checks++;
    if (bus.evt_valid !== 1'b0 || bus.evt_data !== 10'h000) begin
      errors++; $display("FAIL basic_empty: valid=%b data=%h, want 0/000", bus.evt_valid, bus.evt_data);
    end
    checks++;
    if (min_gap < 2) begin
      errors++; $display("FAIL strobe_spacing: min gap %0d cycles, want >=2", min_gap);
    end
  endtask

  task automatic test_ext();
    bit to;
    logic [7:0] bytes [8] = '{8'hE0, 8'h75, 8'hE0, 8'hF0, 8'h75, 8'hF0, 8'hF0, 8'h1C};
    logic [9:0] exp [3] = '{10'h275, 10'h375, 10'h11C};
    foreach (bytes[i]) feed(bytes[i]);
    drain(40, to);
    checks++;
    if (to || bus.evt_count !== 4'd3) begin
      errors++; $display("FAIL ext_count: left=%0d count=%0d, want 0/3", byte_q.size(), bus.evt_count);
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (bus.evt_valid !== 1'b1 || bus.evt_data !== exp[i]) begin
        errors++;
        $display("FAIL ext_event%0d: valid=%b data=%h, want %h", i, bus.evt_valid, bus.evt_data, exp[i]);
      end
      pop_head();
    end
  endtask

  task automatic test_filter();
    bit to;
    feed(8'hE0); feed(8'hAA); feed(8'h1C);
    drain(30, to);
    checks++;
    if (to || bus.evt_count !== 4'd1 || bus.evt_data !== 10'h01C) begin
      errors++;
      $display("FAIL filter_e0_aa: count=%0d data=%h, want 1/01c", bus.evt_count, bus.evt_data);
    end
    pop_head();
    feed(8'hFA); feed(8'h00); feed(8'hFF);
    drain(30, to);
    cyc();
    checks++;
    if (to || bus.evt_count !== 4'd0 || bus.evt_valid !== 1'b0) begin
      errors++; $display("FAIL filter_drop: count=%0d valid=%b, want 0/0", bus.evt_count, bus.evt_valid);
    end
  endtask

  task automatic test_full();
    logic [9:0] exp [7] = '{10'h004, 10'h005, 10'h006, 10'h007, 10'h008, 10'h009, 10'h00A};
    min_gap = 1000;
    last_stb = -1;
    for (int i = 1; i <= 9; i++) feed(8'(i));
    repeat (24) cyc();
    checks++;
    if (bus.evt_count !== 4'd8 || byte_q.size() != 1 || bus.kbd_ready !== 1'b1 ||
        bus.kbd_read_enable !== 1'b0) begin
      errors++;
      $display("FAIL full_hold: count=%0d left=%0d rd=%b, want 8/1/0",
               bus.evt_count, byte_q.size(), bus.kbd_read_enable);
    end
    checks++;
    if (bus.evt_data !== 10'h001) begin
      errors++; $display("FAIL full_head: got %h, want 001", bus.evt_data);
    end
    pop_head();
    cyc();
    checks++;
    if (bus.evt_count !== 4'd8 || byte_q.size() != 0) begin
      errors++; $display("FAIL full_refill: count=%0d left=%0d, want 8/0", bus.evt_count, byte_q.size());
    end
    checks++;
    if (bus.evt_data !== 10'h002) begin
      errors++; $display("FAIL full_head2: got %h, want 002", bus.evt_data);
    end
    pop_head();
    feed(8'h0A);
    checks++;
    if (bus.evt_count !== 4'd7 || bus.evt_data !== 10'h003) begin
      errors++; $display("FAIL full_pre_both: count=%0d data=%h, want 7/003", bus.evt_count, bus.evt_data);
    end
    pop_head();
    checks++;
    if (bus.evt_count !== 4'd7 || byte_q.size() != 0) begin
      errors++;
      $display("FAIL push_pop_same_edge: count=%0d left=%0d, want 7/0", bus.evt_count, byte_q.size());
    end
    for (int i = 0; i < 7; i++) begin
      checks++;
      if (bus.evt_valid !== 1'b1 || bus.evt_data !== exp[i]) begin
        errors++;
        $display("FAIL full_event%0d: valid=%b data=%h, want %h", i, bus.evt_valid, bus.evt_data, exp[i]);
      end
      pop_head();
    end
    checks++;
    if (bus.evt_count !== 4'd0 || min_gap < 2) begin
      errors++; $display("FAIL full_end: count=%0d min_gap=%0d, want 0/>=2", bus.evt_count, min_gap);
    end
  endtask

  task automatic test_overflow();
    bit to;
    feed(8'hF0);
    drain(10, to);
    cyc();
    bus.kbd_overflow = 1'b1;
    cyc();
    checks++;
    if (bus.sync_lost !== 1'b1 || bus.evt_count !== 4'd0) begin
      errors++; $display("FAIL ovf_set: sync=%b count=%0d, want 1/0", bus.sync_lost, bus.evt_count);
    end
    feed(8'h1C);
    drain(10, to);
    checks++;
    if (to || bus.evt_valid !== 1'b1 || bus.evt_data !== 10'h01C) begin
      errors++; $display("FAIL ovf_prefix_drop: valid=%b data=%h, want 1/01c", bus.evt_valid, bus.evt_data);
    end
    pop_head();
    bus.clr_sync_lost = 1'b1;
    cyc();
    checks++;
    if (bus.sync_lost !== 1'b0) begin
      errors++; $display("FAIL ovf_clear: sync=%b, want 0", bus.sync_lost);
    end
    bus.kbd_overflow  = 1'b1;
    bus.clr_sync_lost = 1'b1;
    cyc();
    checks++;
    if (bus.sync_lost !== 1'b1) begin
      errors++; $display("FAIL ovf_set_wins: sync=%b, want 1", bus.sync_lost);
    end
    feed(8'hE0);
    drain(10, to);
    cyc();
    feed(8'h75);
    bus.kbd_overflow = 1'b1;
    cyc();
    checks++;
    if (bus.evt_count !== 4'd1 || bus.evt_data !== 10'h075) begin
      errors++; $display("FAIL ovf_same_edge: count=%0d data=%h, want 1/075", bus.evt_count, bus.evt_data);
    end
    pop_head();
    bus.clr_sync_lost = 1'b1;
    cyc();
  endtask

  task automatic test_reset_mid();
    bit to;
    feed(8'h1C);
    drain(10, to);
    bus.kbd_overflow = 1'b1;
    cyc();
    feed(8'hE0);
    drain(10, to);
    cyc();
    feed(8'h1C);
    #1;
    checks++;
    if (bus.kbd_read_enable !== 1'b1 || bus.evt_count !== 4'd1 || bus.sync_lost !== 1'b1) begin
      errors++;
      $display("FAIL mid_pre_reset: rd=%b count=%0d sync=%b, want 1/1/1",
               bus.kbd_read_enable, bus.evt_count, bus.sync_lost);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (bus.evt_valid !== 1'b0 || bus.evt_count !== 4'd0 || bus.sync_lost !== 1'b0 ||
        bus.kbd_read_enable !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: valid=%b count=%0d sync=%b rd=%b, want all 0",
               bus.evt_valid, bus.evt_count, bus.sync_lost, bus.kbd_read_enable);
    end
    byte_q.delete();
    upd_kbd();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    feed(8'h1C);
    drain(10, to);
    checks++;
    if (to || bus.evt_count !== 4'd1 || bus.evt_data !== 10'h01C) begin
      errors++; $display("FAIL mid_after: count=%0d data=%h, want 1/01c", bus.evt_count, bus.evt_data);
    end
    pop_head();
  endtask

  initial begin
    rst               = 1'b1;
    bus.kbd_ready     = 1'b0;
    bus.kbd_data      = 8'h00;
    bus.kbd_overflow  = 1'b0;
    bus.evt_pop       = 1'b0;
    bus.clr_sync_lost = 1'b0;
    test_reset();
    test_basic();
    test_ext();
    test_filter();
    test_full();
    test_overflow();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
